toggle_monitor: RTL and testbench
=================================

Name: toggle_monitor

Overview:
- Receive-side checker for the two-vector toggle stream driven onto the 5-bit output bus by the toggle generator.
- Samples the bus in the generator's 200 MHz clock domain and checks that it alternates only between expVEC1 (setup phase) and expVEC2 (hold phase).
- Checks phase lengths against the programmed setup/hold cycle counts and counts completed toggles up to cntUPTO.
- Reports done, or a sticky error with a cause code. Used on-board and in benches for loopback self-check of the toggle path.

Parameters:
VEC_W, 5, width of monitored vector
CNT_W, 12, width of toggle counter and cntUPTO
SETUP_CYC, 3, required expVEC1 run length between toggles (cycles)
HOLD_CYC, 2, required expVEC2 run length (cycles)
TIMEOUT_CYC, 4095, max cycles any single run may last before timeout error

Ports:
clk  in  1  200 MHz monitor clock (same clock as generator)
reset  in  1  synchronous, active-high reset
enable  in  1  arm monitor; low returns to idle
cntUPTO  in  CNT_W  expected toggle count; sampled on arming
expVEC1  in  VEC_W  expected setup-phase vector
expVEC2  in  VEC_W  expected hold-phase vector
vec_in  in  VEC_W  monitored bus
done  out  1  pass; held until enable low
error  out  1  fail; sticky until enable low
err_code  out  3  cause: 000 none, 001 illegal vector, 010 setup length, 011 hold length, 100 timeout, 101 config
toggleCNT_out  out  CNT_W  completed toggles so far
state_out  out  3  current state (debug)
err_run  out  12  run length at first error (MON_CAPTURE_EN only)

Behaviour:
- Reset, sync active-high: state MON_WAIT; done=0, error=0, err_code=000, toggleCNT_out=0, run counter=0, vec_q=0, err_run=0.
- vec_in registered into vec_q every cycle.
- A transition is a cycle where vec_q differs from its previous value.
- Status outputs are registered and update on the edge after detection, i.e. 2 edges after vec_in changes.
- Run counter: set to 1 on a transition, +1 per unchanged cycle, saturates at TIMEOUT_CYC.
- States: MON_WAIT, MON_LOW, MON_HIGH, MON_DONE, MON_ERR.
- MON_WAIT:
  - On enable=1, latch cntUPTO.
  - If cntUPTO==0 or expVEC1==expVEC2: go MON_ERR, code 101.
  - Otherwise: go MON_LOW, clear toggle count and run counter, set first-run flag.
- MON_LOW (expects expVEC1):
  - vec_q neither expVEC1 nor expVEC2: error 001.
  - Transition to expVEC2: check the LOW run. First run must be >= SETUP_CYC, since the generator idles in expVEC1 awaiting PLL lock. Later runs must be == SETUP_CYC. Violation: error 010.
  - Check passes: toggle count +1, clear first-run flag, go MON_HIGH.
- MON_HIGH (expects expVEC2):
  - Illegal vector: error 001.
  - Transition to expVEC1 with count < latched cntUPTO: run must == HOLD_CYC, else error 011; pass goes MON_LOW.
  - Transition with count == cntUPTO: final hold run accepted if HOLD_CYC or HOLD_CYC+1, since the generator holds one extra cycle before done. Pass goes MON_DONE with done=1.
- Timeout: in MON_LOW or MON_HIGH, run counter reaching TIMEOUT_CYC gives error 100. The first LOW run is not exempt.
- MON_DONE:
  - done=1, toggleCNT_out frozen.
  - Any further transition: error 001.
  - enable=0: go MON_WAIT, done=0, count=0.
- MON_ERR:
  - error=1; err_code holds the first cause and is never overwritten.
  - enable=0: go MON_WAIT, clear error, err_code and count.
- Simultaneous events: the error check wins over advancing state. Illegal vector (001) beats length errors (010/011), which beat timeout (100).
- enable=0 in MON_LOW or MON_HIGH: go MON_WAIT next edge; no error, no done, count cleared.
- reset mid-operation: same as reset state, regardless of enable.
- toggleCNT_out is CNT_W bits and never exceeds latched cntUPTO, so it does not wrap.

Optional Feature:
- Macro MON_CAPTURE_EN.
- Defined: on entry to MON_ERR, err_run captures the run counter value at the failing cycle (zero-extended); cleared on return to MON_WAIT.
- Not defined: err_run port still exists, tied to 0, no capture registers.

Test Plan:
- Nominal: cntUPTO=4, vectors 5'h0A/5'h15, 10 cycles idle expVEC1 then 3/2 pattern, final hold 3 -> done=1 two edges after last expVEC1, toggleCNT_out=4, error=0.
- Setup short: second LOW run 2 cycles, cntUPTO=4 -> error=1, err_code=010, toggleCNT_out=1, err_run=2 with MON_CAPTURE_EN.
- Hold long: intermediate HIGH run 3 cycles, cntUPTO=4 -> err_code=011; final HIGH run 4 cycles -> err_code=011.
- Illegal vector 5'h1F for one cycle in MON_HIGH -> err_code=001; later length faults do not change code; enable low clears all.
- Config: cntUPTO=0, or expVEC1==expVEC2=5'h03 -> err_code=101 one edge after enable; vec_in held 4095 cycles after arming -> err_code=100.
- enable dropped mid-HIGH at count 2 -> MON_WAIT, done=0, error=0, toggleCNT_out=0; reset asserted in MON_DONE -> all outputs 0 next edge.

Source files
------------

// File: rtl/toggle_monitor_if.sv
// ---------------------------------------------------------------------------
// toggle_monitor_if
//   Bundles the control, expected-vector, monitored-bus and status signals of
//   the toggle monitor. The master side (board logic or bench) drives
//   configuration and the monitored bus. The slave side (the monitor) returns
//   status.
//
//   Signals:
//     enable         arm monitor; low returns to idle
//     cntUPTO        expected toggle count, sampled on arming
//     expVEC1        expected setup-phase vector
//     expVEC2        expected hold-phase vector
//     vec_in         monitored bus
//     done           pass, held until enable low
//     error          fail, sticky until enable low
//     err_code       failure cause
//     toggleCNT_out  completed toggles so far
//     state_out      current monitor state (debug)
//     err_run        run length at first error (capture build only)
// ---------------------------------------------------------------------------
interface toggle_monitor_if #(
    parameter int VEC_W = 5,
    parameter int CNT_W = 12
);
    logic             enable;
    logic [CNT_W-1:0] cntUPTO;
    logic [VEC_W-1:0] expVEC1;
    logic [VEC_W-1:0] expVEC2;
    logic [VEC_W-1:0] vec_in;
    logic             done;
    logic             error;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] toggleCNT_out;
    logic [2:0]       state_out;
    logic [11:0]      err_run;

    modport master (
        output enable, cntUPTO, expVEC1, expVEC2, vec_in,
        input  done, error, err_code, toggleCNT_out, state_out, err_run
    );

    modport slave (
        input  enable, cntUPTO, expVEC1, expVEC2, vec_in,
        output done, error, err_code, toggleCNT_out, state_out, err_run
    );
endinterface

// File: rtl/toggle_monitor.sv
// ---------------------------------------------------------------------------
// toggle_monitor
//   Receive-side checker for the two-vector toggle stream. It samples the
//   monitored bus in the generator clock domain. It checks that the bus
//   alternates between expVEC1 (setup phase) and expVEC2 (hold phase), and
//   that every phase lasts the programmed number of cycles. It counts
//   completed toggles up to cntUPTO and then reports done. On any fault it
//   reports a sticky error with the first cause code.
//
//   Ports:
//     clk    200 MHz monitor clock (same clock as the generator)
//     reset  synchronous, active-high reset
//     bus    toggle_monitor_if.slave: enable, cntUPTO, expVEC1/2, vec_in in;
//            done, error, err_code, toggleCNT_out, state_out, err_run out
//
//   err_code: 0 none, 1 illegal vector, 2 setup length, 3 hold length,
//             4 timeout, 5 config
//
//   Build option: define MON_CAPTURE_EN to capture the run length at the
//   first error on err_run. Otherwise err_run is tied to zero.
// ---------------------------------------------------------------------------
module toggle_monitor #(
    parameter int VEC_W       = 5,
    parameter int CNT_W       = 12,
    parameter int SETUP_CYC   = 3,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input logic             clk,
    input logic             reset,
    toggle_monitor_if.slave bus
);

    localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT_CYC);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_SETUP   = 3'd2;
    localparam logic [2:0] ERR_HOLD    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_CONFIG  = 3'd5;

    typedef enum logic [2:0] {
        MON_WAIT = 3'd0,
        MON_LOW  = 3'd1,
        MON_HIGH = 3'd2,
        MON_DONE = 3'd3,
        MON_ERR  = 3'd4
    } mon_state_e;

    mon_state_e       state_q, state_n;
    logic [VEC_W-1:0] vec_p0, vec_p1;
    logic [RUN_W-1:0] run_q, run_n;
    logic [CNT_W-1:0] upto_q, upto_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             first_q, first_n;
    logic [2:0]       code_q, code_n;
    logic             done_q, error_q;

    logic             transition, is_v1, is_v2, illegal;
    logic             rise, fall, setup_ok, hold_ok, last_toggle, timeout;
    logic             fail;
    logic [2:0]       fail_code;

    // ---- stage p0/p1: bus sample and previous sample ----
    assign transition = (vec_p0 != vec_p1);
    assign is_v1      = (vec_p0 == bus.expVEC1);
    assign is_v2      = (vec_p0 == bus.expVEC2);
    assign illegal    = !is_v1 && !is_v2;
    assign rise       = transition && is_v2;
    assign fall       = transition && is_v1;

    // On a transition cycle run_q still holds the length of the run just
    // ended. The first setup run is open-ended because the generator idles
    // in expVEC1 until its PLL locks.
    assign setup_ok    = first_q ? (run_q >= RUN_W'(SETUP_CYC))
                                 : (run_q == RUN_W'(SETUP_CYC));
    assign last_toggle = (cnt_q == upto_q);
    // The generator holds one extra cycle before it raises its own done.
    assign hold_ok     = last_toggle ? ((run_q == RUN_W'(HOLD_CYC)) ||
                                        (run_q == RUN_W'(HOLD_CYC + 1)))
                                     : (run_q == RUN_W'(HOLD_CYC));
    assign timeout     = (run_q == RUN_MAX);

    always_comb begin
        run_n = run_q;
        if (state_q == MON_WAIT) begin
            run_n = '0;
        end else if (transition) begin
            run_n = RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_n = run_q + RUN_W'(1);
        end
    end

    // Error causes are tested first so that a fault always beats advancing.
    // The order also ranks illegal vector above length above timeout.
    always_comb begin
        state_n   = state_q;
        upto_n    = upto_q;
        cnt_n     = cnt_q;
        first_n   = first_q;
        code_n    = code_q;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (state_q)
            MON_WAIT: begin
                cnt_n  = '0;
                code_n = ERR_NONE;
                if (bus.enable) begin
                    upto_n = bus.cntUPTO;
                    if ((bus.cntUPTO == '0) || (bus.expVEC1 == bus.expVEC2)) begin
                        fail      = 1'b1;
                        fail_code = ERR_CONFIG;
                    end else begin
                        state_n = MON_LOW;
                        first_n = 1'b1;
                    end
                end
            end
            MON_LOW: begin
                if (!bus.enable) begin
                    state_n = MON_WAIT;
                    cnt_n   = '0;
                end else if (illegal) begin
                    fail      = 1'b1;
                    fail_code = ERR_ILLEGAL;
                end else if (rise && !setup_ok) begin
                    fail      = 1'b1;
                    fail_code = ERR_SETUP;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (rise) begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    first_n = 1'b0;
                    state_n = MON_HIGH;
                end
            end
            MON_HIGH: begin
                if (!bus.enable) begin
                    state_n = MON_WAIT;
                    cnt_n   = '0;
                end else if (illegal) begin
                    fail      = 1'b1;
                    fail_code = ERR_ILLEGAL;
                end else if (fall && !hold_ok) begin
                    fail      = 1'b1;
                    fail_code = ERR_HOLD;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (fall) begin
                    state_n = last_toggle ? MON_DONE : MON_LOW;
                end
            end
            MON_DONE: begin
                if (!bus.enable) begin
                    state_n = MON_WAIT;
                    cnt_n   = '0;
                end else if (transition) begin
                    fail      = 1'b1;
                    fail_code = ERR_ILLEGAL;
                end
            end
            MON_ERR: begin
                if (!bus.enable) begin
                    state_n = MON_WAIT;
                    cnt_n   = '0;
                    code_n  = ERR_NONE;
                end
            end
            default: state_n = MON_WAIT;
        endcase
        if (fail) begin
            state_n = MON_ERR;
            code_n  = fail_code;
        end
    end

    // ---- stage p2: registered state and status ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MON_WAIT;
            vec_p0  <= '0;
            vec_p1  <= '0;
            run_q   <= '0;
            upto_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            code_q  <= ERR_NONE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_n;
            vec_p0  <= bus.vec_in;
            vec_p1  <= vec_p0;
            run_q   <= run_n;
            upto_q  <= upto_n;
            cnt_q   <= cnt_n;
            first_q <= first_n;
            code_q  <= code_n;
            done_q  <= (state_n == MON_DONE);
            error_q <= (state_n == MON_ERR);
        end
    end

    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.err_code      = code_q;
    assign bus.toggleCNT_out = cnt_q;
    assign bus.state_out     = state_q;

`ifdef MON_CAPTURE_EN
    logic [11:0] err_run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_run_q <= '0;
        end else if (fail && (state_q != MON_ERR)) begin
            err_run_q <= 12'(run_q);
        end else if (state_n == MON_WAIT) begin
            err_run_q <= '0;
        end
    end

    assign bus.err_run = err_run_q;
`else
    assign bus.err_run = '0;
`endif

endmodule

// File: tb/tb_toggle_monitor.sv
`timescale 1ns/1ps
module tb_toggle_monitor;
    localparam int VEC_W  = 5;
    localparam int CNT_W  = 12;
    localparam int SETUP  = 3;
    localparam int HOLD   = 2;
    localparam int TMO    = 4095;
    localparam int NO_EVT = -1000;
`ifdef MON_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq[$];

    toggle_monitor_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) bus();

    toggle_monitor #(
        .VEC_W(VEC_W), .CNT_W(CNT_W), .SETUP_CYC(SETUP),
        .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #2.5 clk = ~clk;

    task automatic add(input int v, input int n);
        for (int i = 0; i < n; i++) seq.push_back(v);
    endtask

    // Idle with enable low so the bus settles at v1, then arm and play seq.
    // evt is the index of the sequence cycle whose detection first raised
    // done or error (-1: raised by the arming check itself).
    task automatic play(input int v1, input int v2, input int upto, output int evt);
        bus.enable  = 1'b0;
        bus.expVEC1 = VEC_W'(v1);
        bus.expVEC2 = VEC_W'(v2);
        bus.cntUPTO = CNT_W'(upto);
        bus.vec_in  = VEC_W'(v1);
        repeat (3) @(negedge clk);
        evt = NO_EVT;
        bus.enable = 1'b1;
        for (int i = 0; i < seq.size(); i++) begin
            bus.vec_in = VEC_W'(seq[i]);
            @(negedge clk);
            if (evt == NO_EVT && (bus.done || bus.error)) evt = i - 1;
        end
        @(negedge clk);
        if (evt == NO_EVT && (bus.done || bus.error)) evt = seq.size() - 1;
    endtask

    // Reference: compress seq into runs, then apply the phase rules run by run.
    task automatic model(input int v1, input int v2, input int upto,
                         output int e_evt, output int e_done, output int e_err,
                         output int e_code, output int e_cnt, output int e_run);
        int rv[$];
        int rl[$];
        int st[$];
        int ph;
        int cnt;
        int r;
        int code;
        bit first;
        bit last;
        e_evt = NO_EVT; e_done = 0; e_err = 0; e_code = 0; e_cnt = 0; e_run = 0;
        if (upto == 0 || v1 == v2) begin
            e_evt = -1; e_err = 1; e_code = 5;
            return;
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 0 || seq[i] != seq[i-1]) begin
                rv.push_back(seq[i]); rl.push_back(1); st.push_back(i);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
        ph = 0; cnt = 0; first = 1'b1;
        for (int k = 0; k < rv.size(); k++) begin
            if (k > 0) begin
                r = (rl[k-1] > TMO) ? TMO : rl[k-1];
                code = 0;
                if (ph == 2 || (rv[k] != v1 && rv[k] != v2)) begin
                    code = 1;
                end else if (ph == 0 && rv[k] == v2) begin
                    if (first ? (r < SETUP) : (r != SETUP)) code = 2;
                    else if (r == TMO) code = 4;
                    else begin cnt++; first = 1'b0; ph = 1; end
                end else if (ph == 1 && rv[k] == v1) begin
                    last = (cnt == upto);
                    if (last ? !(r == HOLD || r == HOLD + 1) : (r != HOLD)) code = 3;
                    else if (r == TMO) code = 4;
                    else if (last) begin
                        ph = 2; e_done = 1;
                        if (e_evt == NO_EVT) e_evt = st[k];
                    end else ph = 0;
                end
                if (code != 0) begin
                    if (e_evt == NO_EVT) e_evt = st[k];
                    e_done = 0; e_err = 1; e_code = code; e_run = r; e_cnt = cnt;
                    return;
                end
            end
            if (ph != 2 && rl[k] > TMO) begin
                if (e_evt == NO_EVT) e_evt = st[k] + TMO;
                e_err = 1; e_code = 4; e_run = TMO; e_cnt = cnt;
                return;
            end
        end
        e_cnt = cnt;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b0; bus.cntUPTO = '0;
        bus.expVEC1 = '0; bus.expVEC2 = '0; bus.vec_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %0b want 0", bus.error); end
        n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", bus.err_code); end
        n_cmp++; if (bus.toggleCNT_out !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.toggleCNT_out); end
        n_cmp++; if (bus.err_run !== 12'd0) begin n_bad++; $display("FAIL reset_err_run: got %0d want 0", bus.err_run); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic nominal_seq();
        seq = {};
        add('h0A, 10);
        for (int t = 0; t < 3; t++) begin add('h15, 2); add('h0A, 3); end
        add('h15, 3); add('h0A, 4);
    endtask

    task automatic test_nominal();
        int evt;
        nominal_seq();
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (evt !== 28) begin n_bad++; $display("FAIL nominal_evt: got %0d want 28", evt); end
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL nominal_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL nominal_error: got %0b want 0", bus.error); end
        n_cmp++; if (bus.toggleCNT_out !== 12'd4) begin n_bad++; $display("FAIL nominal_cnt: got %0d want 4", bus.toggleCNT_out); end
    endtask

    task automatic test_setup_short();
        int evt;
        seq = {};
        add('h0A, 10); add('h15, 2); add('h0A, 2); add('h15, 2); add('h0A, 4);
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (evt !== 14) begin n_bad++; $display("FAIL setup_evt: got %0d want 14", evt); end
        n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL setup_error: got %0b want 1", bus.error); end
        n_cmp++; if (bus.err_code !== 3'd2) begin n_bad++; $display("FAIL setup_code: got %0d want 2", bus.err_code); end
        n_cmp++; if (bus.toggleCNT_out !== 12'd1) begin n_bad++; $display("FAIL setup_cnt: got %0d want 1", bus.toggleCNT_out); end
        n_cmp++; if (bus.err_run !== (CAPTURE ? 12'd2 : 12'd0)) begin n_bad++; $display("FAIL setup_err_run: got %0d want %0d", bus.err_run, CAPTURE ? 2 : 0); end
    endtask

    task automatic test_hold_long();
        int evt;
        seq = {};
        add('h0A, 5); add('h15, 3); add('h0A, 3);
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (evt !== 8) begin n_bad++; $display("FAIL hold_mid_evt: got %0d want 8", evt); end
        n_cmp++; if (bus.err_code !== 3'd3) begin n_bad++; $display("FAIL hold_mid_code: got %0d want 3", bus.err_code); end
        n_cmp++; if (bus.err_run !== (CAPTURE ? 12'd3 : 12'd0)) begin n_bad++; $display("FAIL hold_mid_err_run: got %0d want %0d", bus.err_run, CAPTURE ? 3 : 0); end
        seq = {};
        add('h0A, 5); add('h15, 4); add('h0A, 4);
        play('h0A, 'h15, 1, evt);
        n_cmp++; if (evt !== 9) begin n_bad++; $display("FAIL hold_final_evt: got %0d want 9", evt); end
        n_cmp++; if (bus.err_code !== 3'd3) begin n_bad++; $display("FAIL hold_final_code: got %0d want 3", bus.err_code); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL hold_final_done: got %0b want 0", bus.done); end
    endtask

    task automatic test_illegal();
        int evt;
        seq = {};
        add('h0A, 5); add('h15, 1); add('h1F, 1); add('h15, 1); add('h0A, 1); add('h15, 6); add('h0A, 3);
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (evt !== 6) begin n_bad++; $display("FAIL illegal_evt: got %0d want 6", evt); end
        n_cmp++; if (bus.err_code !== 3'd1) begin n_bad++; $display("FAIL illegal_code: got %0d want 1", bus.err_code); end
        n_cmp++; if (bus.toggleCNT_out !== 12'd1) begin n_bad++; $display("FAIL illegal_cnt: got %0d want 1", bus.toggleCNT_out); end
        bus.enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL illegal_clr_error: got %0b want 0", bus.error); end
        n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL illegal_clr_code: got %0d want 0", bus.err_code); end
        n_cmp++; if (bus.toggleCNT_out !== '0) begin n_bad++; $display("FAIL illegal_clr_cnt: got %0d want 0", bus.toggleCNT_out); end
        n_cmp++; if (bus.err_run !== 12'd0) begin n_bad++; $display("FAIL illegal_clr_err_run: got %0d want 0", bus.err_run); end
    endtask

    task automatic test_config();
        int evt;
        seq = {};
        add('h0A, 3);
        play('h0A, 'h15, 0, evt);
        n_cmp++; if (evt !== -1) begin n_bad++; $display("FAIL cfg_zero_evt: got %0d want -1", evt); end
        n_cmp++; if (bus.err_code !== 3'd5) begin n_bad++; $display("FAIL cfg_zero_code: got %0d want 5", bus.err_code); end
        seq = {};
        add('h03, 3);
        play('h03, 'h03, 4, evt);
        n_cmp++; if (evt !== -1) begin n_bad++; $display("FAIL cfg_same_evt: got %0d want -1", evt); end
        n_cmp++; if (bus.err_code !== 3'd5) begin n_bad++; $display("FAIL cfg_same_code: got %0d want 5", bus.err_code); end
        n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL cfg_same_error: got %0b want 1", bus.error); end
    endtask

    task automatic test_timeout();
        int evt;
        seq = {};
        add('h0A, 4100);
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (evt !== 4095) begin n_bad++; $display("FAIL timeout_evt: got %0d want 4095", evt); end
        n_cmp++; if (bus.err_code !== 3'd4) begin n_bad++; $display("FAIL timeout_code: got %0d want 4", bus.err_code); end
        n_cmp++; if (bus.err_run !== (CAPTURE ? 12'd4095 : 12'd0)) begin n_bad++; $display("FAIL timeout_err_run: got %0d want %0d", bus.err_run, CAPTURE ? 4095 : 0); end
    endtask

    task automatic test_enable_drop();
        int evt;
        seq = {};
        add('h0A, 5); add('h15, 2); add('h0A, 3); add('h15, 2);
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (bus.toggleCNT_out !== 12'd2) begin n_bad++; $display("FAIL drop_pre_cnt: got %0d want 2", bus.toggleCNT_out); end
        bus.enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin n_bad++; $display("FAIL drop_status: got done=%0b error=%0b want 0/0", bus.done, bus.error); end
        n_cmp++; if (bus.toggleCNT_out !== '0) begin n_bad++; $display("FAIL drop_cnt: got %0d want 0", bus.toggleCNT_out); end
    endtask

    task automatic test_reset_mid();
        int evt;
        nominal_seq();
        play('h0A, 'h15, 4, evt);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_done: got %0b want 1", bus.done); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: got done=%0b error=%0b want 0/0", bus.done, bus.error); end
        n_cmp++; if (bus.err_code !== 3'd0 || bus.toggleCNT_out !== '0) begin n_bad++; $display("FAIL rstmid_code_cnt: got code=%0d cnt=%0d want 0/0", bus.err_code, bus.toggleCNT_out); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int v1, v2, ill, upto, evt;
        int e_evt, e_done, e_err, e_code, e_cnt, e_run;
        int h, s;
        for (int t = 0; t < 60; t++) begin
            upto = $urandom_range(1, 5);
            v1 = $urandom_range(0, 31);
            do v2 = $urandom_range(0, 31); while (v2 == v1);
            do ill = $urandom_range(0, 31); while (ill == v1 || ill == v2);
            seq = {};
            add(v1, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12));
            for (int k = 1; k <= upto; k++) begin
                h = (k == upto) ? HOLD + $urandom_range(0, 1) : HOLD;
                if ($urandom_range(0, 7) == 0) h = $urandom_range(1, 4);
                add(v2, h);
                if ($urandom_range(0, 15) == 0) add(ill, 1);
                if (k < upto) begin
                    s = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : SETUP;
                    add(v1, s);
                end
            end
            add(v1, 4);
            if ($urandom_range(0, 5) == 0) begin add(v2, 2); add(v1, 2); end
            model(v1, v2, upto, e_evt, e_done, e_err, e_code, e_cnt, e_run);
            play(v1, v2, upto, evt);
            n_cmp++; if (evt !== e_evt) begin n_bad++; $display("FAIL rand%0d_evt: got %0d want %0d", t, evt, e_evt); end
            n_cmp++; if (bus.done !== e_done[0]) begin n_bad++; $display("FAIL rand%0d_done: got %0b want %0d", t, bus.done, e_done); end
            n_cmp++; if (bus.error !== e_err[0]) begin n_bad++; $display("FAIL rand%0d_error: got %0b want %0d", t, bus.error, e_err); end
            n_cmp++; if (bus.err_code !== 3'(e_code)) begin n_bad++; $display("FAIL rand%0d_code: got %0d want %0d", t, bus.err_code, e_code); end
            n_cmp++; if (bus.toggleCNT_out !== CNT_W'(e_cnt)) begin n_bad++; $display("FAIL rand%0d_cnt: got %0d want %0d", t, bus.toggleCNT_out, e_cnt); end
            n_cmp++; if (bus.err_run !== (CAPTURE ? 12'(e_run) : 12'd0)) begin n_bad++; $display("FAIL rand%0d_err_run: got %0d want %0d", t, bus.err_run, CAPTURE ? e_run : 0); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_setup_short();
        test_hold_long();
        test_illegal();
        test_config();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
